// File: rtl/morse_sequencer.sv
// Morse keyer: buffers ASCII characters in a FIFO and keys them out as ITU Morse.
// Define MORSE_SEQ_PUNCT_EN to add '.', ',', '?' and '/' with a 6-element code table.
module morse_sequencer #(
    parameter int unsigned FIFO_DEPTH     = 14,
    parameter int unsigned DIT_CYCLES     = 1000000,
    parameter int unsigned CHAR_GAP_UNITS = 3,
    parameter int unsigned WORD_GAP_UNITS = 7
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [7:0]                      char_data,
    input  logic                            char_valid,
    output logic                            char_ready,
    input  logic [1:0]                      speed_sel,
    output logic                            morse_out,
    output logic                            dit_out,
    output logic                            dah_out,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
    output logic                            invalid_char
);

`ifdef MORSE_SEQ_PUNCT_EN
    localparam int unsigned NE = 6;
`else
    localparam int unsigned NE = 5;
`endif

    localparam int unsigned CW   = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
    localparam int unsigned UW   = $clog2((DIT_CYCLES << 3) + 1);
    localparam int unsigned MaxU = (WORD_GAP_UNITS > 3) ? WORD_GAP_UNITS : 3;
    localparam int unsigned GW   = $clog2(MaxU + 1);
    localparam logic [UW-1:0] UnitBase = UW'(DIT_CYCLES);

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StMark,
        StElemGap,
        StCharGap,
        StWordGap
    } state_e;

    // Entry layout: {supported, length[2:0], pattern}; pattern is first element at MSB, 1 = dah.
    function automatic logic [NE+3:0] code_entry(input logic [2:0] len, input logic [4:0] pat);
        logic [NE-1:0] p;
        p = '0;
        p[NE-1 -: 5] = pat;
        return {1'b1, len, p};
    endfunction

    function automatic logic [NE+3:0] code_lookup(input logic [7:0] ch);
        logic [7:0]    c;
        logic [NE+3:0] r;
        c = (ch >= "a" && ch <= "z") ? ch - 8'd32 : ch;
        r = '0;
        case (c)
            "A": r = code_entry(3'd2, 5'b01000);
            "B": r = code_entry(3'd4, 5'b10000);
            "C": r = code_entry(3'd4, 5'b10100);
            "D": r = code_entry(3'd3, 5'b10000);
            "E": r = code_entry(3'd1, 5'b00000);
            "F": r = code_entry(3'd4, 5'b00100);
            "G": r = code_entry(3'd3, 5'b11000);
            "H": r = code_entry(3'd4, 5'b00000);
            "I": r = code_entry(3'd2, 5'b00000);
            "J": r = code_entry(3'd4, 5'b01110);
            "K": r = code_entry(3'd3, 5'b10100);
            "L": r = code_entry(3'd4, 5'b01000);
            "M": r = code_entry(3'd2, 5'b11000);
            "N": r = code_entry(3'd2, 5'b10000);
            "O": r = code_entry(3'd3, 5'b11100);
            "P": r = code_entry(3'd4, 5'b01100);
            "Q": r = code_entry(3'd4, 5'b11010);
            "R": r = code_entry(3'd3, 5'b01000);
            "S": r = code_entry(3'd3, 5'b00000);
            "T": r = code_entry(3'd1, 5'b10000);
            "U": r = code_entry(3'd3, 5'b00100);
            "V": r = code_entry(3'd4, 5'b00010);
            "W": r = code_entry(3'd3, 5'b01100);
            "X": r = code_entry(3'd4, 5'b10010);
            "Y": r = code_entry(3'd4, 5'b10110);
            "Z": r = code_entry(3'd4, 5'b11000);
            "0": r = code_entry(3'd5, 5'b11111);
            "1": r = code_entry(3'd5, 5'b01111);
            "2": r = code_entry(3'd5, 5'b00111);
            "3": r = code_entry(3'd5, 5'b00011);
            "4": r = code_entry(3'd5, 5'b00001);
            "5": r = code_entry(3'd5, 5'b00000);
            "6": r = code_entry(3'd5, 5'b10000);
            "7": r = code_entry(3'd5, 5'b11000);
            "8": r = code_entry(3'd5, 5'b11100);
            "9": r = code_entry(3'd5, 5'b11110);
`ifdef MORSE_SEQ_PUNCT_EN
            ".": r = {1'b1, 3'd6, 6'b010101};
            ",": r = {1'b1, 3'd6, 6'b110011};
            "?": r = {1'b1, 3'd6, 6'b001100};
            "/": r = {1'b1, 3'd5, 6'b100100};
`endif
            default: r = '0;
        endcase
        return r;
    endfunction

    // FIFO
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            push, pop, fifo_empty;
    logic [7:0]      head;

    assign fifo_count = count_q;
    assign char_ready = (count_q != CW'(FIFO_DEPTH));
    assign push       = char_valid && char_ready;
    assign fifo_empty = (count_q == '0);
    assign head       = mem_q[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PtrW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= char_data;
        end
    end

    // Sequencer
    state_e        state_q, state_d;
    logic [7:0]    char_q, char_d;
    logic [NE-1:0] pat_q, pat_d;
    logic [2:0]    left_q, left_d;
    logic [UW-1:0] unit_len_q, unit_len_d, unit_cnt_q, unit_cnt_d;
    logic [GW-1:0] phase_q, phase_d, target;
    logic          dit_q, dit_d, dah_q, dah_d, inv_q, inv_d;
    logic [NE+3:0] code;
    logic          code_ok, is_space, timed, unit_end, phase_last, done, pre_last;
    logic [2:0]    code_len;
    logic [NE-1:0] code_pat;

    assign code     = code_lookup(char_q);
    assign code_ok  = code[NE+3];
    assign code_len = code[NE+2:NE];
    assign code_pat = code[NE-1:0];
    assign is_space = (char_q == 8'h20);

    always_comb begin
        case (state_q)
            StMark:    target = pat_q[NE-1] ? GW'(3) : GW'(1);
            StCharGap: target = GW'(CHAR_GAP_UNITS);
            StWordGap: target = GW'(WORD_GAP_UNITS - CHAR_GAP_UNITS);
            default:   target = GW'(1);
        endcase
    end

    assign timed      = (state_q == StMark) || (state_q == StElemGap) ||
                        (state_q == StCharGap) || (state_q == StWordGap);
    assign unit_end   = (unit_cnt_q == unit_len_q - UW'(1));
    assign phase_last = (phase_q == target - GW'(1));
    assign done       = unit_end && phase_last;

    // Second-to-last cycle of a gap: the following LOAD cycle is charged to the gap.
    always_comb begin
        if (unit_len_q > UW'(1)) begin
            pre_last = phase_last && (unit_cnt_q == unit_len_q - UW'(2));
        end else begin
            pre_last = (phase_q == target - GW'(2));
        end
    end

    always_comb begin
        state_d    = state_q;
        char_d     = char_q;
        pat_d      = pat_q;
        left_d     = left_q;
        unit_len_d = unit_len_q;
        unit_cnt_d = unit_cnt_q;
        phase_d    = phase_q;
        dit_d      = 1'b0;
        dah_d      = 1'b0;
        inv_d      = 1'b0;
        pop        = 1'b0;

        if (timed) begin
            if (unit_end) begin
                unit_cnt_d = '0;
                phase_d    = phase_q + GW'(1);
            end else begin
                unit_cnt_d = unit_cnt_q + UW'(1);
            end
        end

        case (state_q)
            StIdle: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    char_d  = head;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                unit_len_d = UnitBase << speed_sel;
                unit_cnt_d = '0;
                phase_d    = '0;
                if (code_ok) begin
                    pat_d   = code_pat;
                    left_d  = code_len;
                    dit_d   = !code_pat[NE-1];
                    dah_d   = code_pat[NE-1];
                    state_d = StMark;
                end else if (is_space) begin
                    state_d = StWordGap;
                end else begin
                    inv_d = 1'b1;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        char_d  = head;
                        state_d = StLoad;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            StMark: begin
                if (done) begin
                    unit_cnt_d = '0;
                    phase_d    = '0;
                    if (left_q > 3'd1) begin
                        left_d  = left_q - 3'd1;
                        pat_d   = pat_q << 1;
                        state_d = StElemGap;
                    end else begin
                        state_d = StCharGap;
                    end
                end else begin
                    dit_d = dit_q;
                    dah_d = dah_q;
                end
            end
            StElemGap: begin
                if (done) begin
                    unit_cnt_d = '0;
                    phase_d    = '0;
                    dit_d      = !pat_q[NE-1];
                    dah_d      = pat_q[NE-1];
                    state_d    = StMark;
                end
            end
            StCharGap, StWordGap: begin
                if ((!fifo_empty && pre_last) || done) begin
                    unit_cnt_d = '0;
                    phase_d    = '0;
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        char_d  = head;
                        state_d = StLoad;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            char_q     <= '0;
            pat_q      <= '0;
            left_q     <= '0;
            unit_len_q <= UnitBase;
            unit_cnt_q <= '0;
            phase_q    <= '0;
            dit_q      <= 1'b0;
            dah_q      <= 1'b0;
            inv_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            char_q     <= char_d;
            pat_q      <= pat_d;
            left_q     <= left_d;
            unit_len_q <= unit_len_d;
            unit_cnt_q <= unit_cnt_d;
            phase_q    <= phase_d;
            dit_q      <= dit_d;
            dah_q      <= dah_d;
            inv_q      <= inv_d;
        end
    end

    assign dit_out      = dit_q;
    assign dah_out      = dah_q;
    assign morse_out    = dit_q | dah_q;
    assign invalid_char = inv_q;
    assign busy         = (state_q != StIdle) || !fifo_empty;

endmodule

// File: doc/morse_sequencer.md
MORSE_SEQUENCER -- requirements
Module: morse_sequencer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 14, character buffer depth (2..64, any integer, not restricted to powers of two).
REQ-002 SHALL have parameter DIT_CYCLES, default 1000000, clk cycles per Morse unit at speed_sel=0.
REQ-003 SHALL have parameter CHAR_GAP_UNITS, default 3, low units after the last element of a character.
REQ-004 SHALL have parameter WORD_GAP_UNITS, default 7, total low units between words.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic rising-edge.
REQ-006 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-007 SHALL have port char_data, input, 8, ASCII character.
REQ-008 SHALL have port char_valid, input, 1, char_data is offered.
REQ-009 SHALL have port char_ready, output, 1, FIFO can accept a character.
REQ-010 SHALL have port speed_sel, input, 2, unit length = DIT_CYCLES << speed_sel.
REQ-011 SHALL have port morse_out, output, 1, keyed Morse signal (high = mark).
REQ-012 SHALL have port dit_out, output, 1, high during dit marks only.
REQ-013 SHALL have port dah_out, output, 1, high during dah marks only.
REQ-014 SHALL have port busy, output, 1, FSM not IDLE or FIFO non-empty.
REQ-015 SHALL have port fifo_count, output, $clog2(FIFO_DEPTH+1), stored character count.
REQ-016 SHALL have port invalid_char, output, 1, one-cycle pulse when an unsupported character is discarded.

Function
REQ-017 SHALL accept a character on a rising edge where char_valid and char_ready are both high; char_ready = (fifo_count != FIFO_DEPTH), combinational from count.
REQ-018 SHALL NOT accept a push when full, even if a pop occurs in the same cycle; a simultaneous push and pop when not full SHALL leave fifo_count unchanged.
REQ-019 SHALL wrap read and write pointers modulo FIFO_DEPTH.
REQ-020 SHALL implement FSM states IDLE, LOAD, MARK, ELEM_GAP, CHAR_GAP, WORD_GAP.
REQ-021 SHALL transition IDLE->LOAD when the FIFO is non-empty, popping the head; in LOAD it SHALL look up the code and latch the unit length from speed_sel.
REQ-022 SHALL hold the latched unit length constant for the whole character, including its gaps.
REQ-023 SHALL map A-Z, a-z (case-folded) and 0-9 to ITU Morse, each code being up to 5 elements with a 3-bit length.
REQ-024 SHALL, for a supported character, go LOAD->MARK; MARK lasts 1 unit (dit) or 3 units (dah); then ELEM_GAP for 1 unit if elements remain, else CHAR_GAP.
REQ-025 SHALL hold CHAR_GAP for CHAR_GAP_UNITS units, then go to LOAD if the FIFO is non-empty, else IDLE.
REQ-026 SHALL, for a space (0x20), go LOAD->WORD_GAP for WORD_GAP_UNITS-CHAR_GAP_UNITS units with no mark, then LOAD or IDLE.
REQ-027 SHALL, for any other code, go LOAD->IDLE or LOAD with no mark and pulse invalid_char for exactly 1 cycle.
REQ-028 SHALL register morse_out, dit_out and dah_out; morse_out = dit_out | dah_out at all times.
REQ-029 SHALL give a latency of 2 cycles: a character accepted at edge t0 into an empty FIFO while IDLE gives LOAD after t1 and morse_out high after t2.
REQ-030 SHALL size the unit counter for DIT_CYCLES<<3 and the mark/gap counter for max(3, WORD_GAP_UNITS) units.

Reset
REQ-031 SHALL, on rst high, immediately force morse_out, dit_out, dah_out, invalid_char and busy to 0, fifo_count to 0, char_ready to 1, FSM to IDLE and pointers to 0, including mid-mark.
REQ-032 SHALL discard FIFO contents on reset; the first character after rst deasserts SHALL follow REQ-029.

Configuration
REQ-033 SHALL, with macro MORSE_SEQ_PUNCT_EN defined, widen the code table to 6 elements and support '.' (.-.-.-), ',' (--..--), '?' (..--..) and '/' (-..-.).
REQ-034 SHALL, without MORSE_SEQ_PUNCT_EN, treat those four characters as unsupported per REQ-027 and keep the table at 5 elements.

Verification (DIT_CYCLES=4, speed_sel=0 unless stated)
REQ-035 SHALL check: push 'E' while idle -> morse_out and dit_out high 4 cycles starting 2 cycles after accept, then 12 low cycles, then busy=0.
REQ-036 SHALL check: push 'a' -> high 4, low 4, high 12 with dah_out=1, low 12; speed_sel=2 -> every duration x4.
REQ-037 SHALL check: 'E',' ','E' -> exactly 28 low cycles between the two marks.
REQ-038 SHALL check: push back-to-back during the first mark -> FIFO_DEPTH further accepts, fifo_count=14, char_ready=0, then the next char is accepted only after a pop.
REQ-039 SHALL check: push '#' -> no mark, invalid_char high 1 cycle; '?' -> ..--.. only with MORSE_SEQ_PUNCT_EN, else an invalid_char pulse.
REQ-040 SHALL check: rst asserted mid-dah -> all outputs 0 in the same cycle, fifo_count=0.
